key_scan_ctrl: RTL and testbench

//  Column-scan sequencer and debouncer for the 4-column x 5-row key matrix (20 keys) used by timer_top.

---
 rtl/key_scan_pkg.sv | 30 +++
 rtl/key_col_scanner.sv | 69 ++++++
 rtl/key_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared definitions for the key matrix scanner.
//   - Matrix geometry (4 columns x 5 rows) and the "no key" code.
//   - Debounce FSM state encoding.
//   - key_code(): matrix position to key code (row*4 + col + 1).
//   - code_min(): lowest nonzero code of two, used to resolve multi-key presses.
package key_scan_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 5;
  localparam logic [4:0]  KEY_NONE = 5'd0;

  typedef logic [1:0] key_state_t;

  localparam key_state_t IDLE     = 2'd0;
  localparam key_state_t PRESS_DB = 2'd1;
  localparam key_state_t HELD     = 2'd2;
  localparam key_state_t REL_DB   = 2'd3;

  function automatic logic [4:0] key_code(input logic [2:0] row, input logic [1:0] col);
    return {row, 2'b00} + {3'b000, col} + 5'd1;
  endfunction

  // KEY_NONE never wins against a real code.
  function automatic logic [4:0] code_min(input logic [4:0] a, input logic [4:0] b);
    if (a == KEY_NONE) return b;
    if (b == KEY_NONE) return a;
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/key_col_scanner.sv
// Column scan sequencer for the key matrix.
// Drives one column at a time for SCAN_DIV clocks, samples the rows on the last clock of each
// column and reduces one full frame (all 4 columns) to the lowest pressed key code.
// Ports:
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_key_in        matrix rows, active-high
//   o_key_out       registered one-hot column drive
//   o_frame_done    1-cycle strobe on the column-3 sample cycle (frame complete)
//   o_frame_code    lowest code seen in the frame, KEY_NONE if empty; valid with o_frame_done
module key_col_scanner
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NUM_ROWS-1:0] i_key_in,
  output logic [NUM_COLS-1:0] o_key_out,
  output logic                o_frame_done,
  output logic [4:0]          o_frame_code
);

  localparam int unsigned      TickW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(SCAN_DIV - 1);

  logic [TickW-1:0]    tick_q, tick_d;
  logic [1:0]          col_q, col_d;
  logic [NUM_COLS-1:0] key_out_q, key_out_d;
  logic [4:0]          frame_min_q, frame_min_d;
  logic [4:0]          col_code;
  logic                sample;

  // Lowest asserted row gives the lowest code within the current column.
  always_comb begin
    col_code = KEY_NONE;
    for (int r = int'(NUM_ROWS) - 1; r >= 0; r--) begin
      if (i_key_in[r]) col_code = key_code(3'(r), col_q);
    end
  end

  always_comb begin
    sample       = (tick_q == TickLast);
    tick_d       = sample ? '0 : tick_q + TickW'(1);
    col_d        = col_q + {1'b0, sample};
    // Drive the new column on the same edge col_idx advances, so it is settled by the sample.
    key_out_d    = 4'b0001 << col_d;
    o_frame_code = code_min(frame_min_q, col_code);
    o_frame_done = sample && (col_q == 2'(NUM_COLS - 1));
    frame_min_d  = frame_min_q;
    if (sample) frame_min_d = o_frame_done ? KEY_NONE : o_frame_code;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tick_q      <= '0;
      col_q       <= 2'd0;
      key_out_q   <= 4'b0001;
      frame_min_q <= KEY_NONE;
    end else begin
      tick_q      <= tick_d;
      col_q       <= col_d;
      key_out_q   <= key_out_d;
      frame_min_q <= frame_min_d;
    end
  end

  assign o_key_out = key_out_q;

endmodule

// File: rtl/key_scan_ctrl.sv
// Key matrix controller: column scanning plus frame-based debouncing.
// A key is accepted after DEBOUNCE_FRAMES consecutive frames with the same lowest code and is
// released after DEBOUNCE_FRAMES consecutive frames without it.
// Ports:
//   i_clk, i_rstn   clock (10 MHz nominal), asynchronous active-low reset
//   i_key_in        matrix rows, active-high, row r = bit r
//   o_key_out       matrix column drive, one-hot active-high
//   o_key_valid     1-cycle pulse when a press is accepted
//   o_key_code      last accepted code (row*4 + col + 1), 0 after reset
//   o_key_hold      accepted key still pressed
//   o_key_release   1-cycle pulse when the held key is released
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 10000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NUM_ROWS-1:0] i_key_in,
  output logic [NUM_COLS-1:0] o_key_out,
  output logic                o_key_valid,
  output logic [4:0]          o_key_code,
  output logic                o_key_hold,
  output logic                o_key_release
);

  localparam int unsigned     CntW      = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CntW-1:0] CntTarget = CntW'(DEBOUNCE_FRAMES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  logic       frame_done;
  logic [4:0] frame_code;

  key_col_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scanner (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_key_in    (i_key_in),
    .o_key_out   (o_key_out),
    .o_frame_done(frame_done),
    .o_frame_code(frame_code)
  );

  key_state_t      state_q, state_d;
  logic [4:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            hold_q, hold_d;
  logic            release_q, release_d;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    hold_d    = hold_q;
    valid_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = cnt_q + CntOne;

    if (frame_done) begin
      unique case (state_q)
        IDLE: begin
          if (frame_code != KEY_NONE) begin
            cand_d = frame_code;
            if (CntTarget == CntOne) begin
              state_d = HELD;
              cnt_d   = '0;
              code_d  = frame_code;
              valid_d = 1'b1;
              hold_d  = 1'b1;
            end else begin
              state_d = PRESS_DB;
              cnt_d   = CntOne;
            end
          end
        end
        PRESS_DB: begin
          if (frame_code == cand_q) begin
            if (cnt_inc == CntTarget) begin
              state_d = HELD;
              cnt_d   = '0;
              code_d  = cand_q;
              valid_d = 1'b1;
              hold_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (frame_code == KEY_NONE) begin
            state_d = IDLE;
            cand_d  = KEY_NONE;
            cnt_d   = '0;
          end else begin
            // A different key restarts the debounce with the new candidate.
            cand_d = frame_code;
            cnt_d  = CntOne;
          end
        end
        HELD: begin
          if (frame_code != cand_q) begin
            if (CntTarget == CntOne) begin
              state_d   = IDLE;
              cand_d    = KEY_NONE;
              cnt_d     = '0;
              hold_d    = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = REL_DB;
              cnt_d   = CntOne;
            end
          end
        end
        REL_DB: begin
          if (frame_code == cand_q) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_inc == CntTarget) begin
            state_d   = IDLE;
            cand_d    = KEY_NONE;
            cnt_d     = '0;
            hold_d    = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      cand_q    <= KEY_NONE;
      cnt_q     <= '0;
      code_q    <= KEY_NONE;
      valid_q   <= 1'b0;
      hold_q    <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      release_q <= release_d;
    end
  end

  assign o_key_valid   = valid_q;
  assign o_key_code    = code_q;
  assign o_key_hold    = hold_q;
  assign o_key_release = release_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
module tb_key_scan_ctrl;

  localparam int SD = 4;  // clocks per column
  localparam int DB = 3;  // debounce frames
  localparam int FR = 4 * SD;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] key_in;
  logic [3:0] key_out;
  logic       valid;
  logic [4:0] code;
  logic       hold;
  logic       rel;

  // Matrix model: pressed[r][c] is key (row r, column c).
  logic [3:0] pressed [5];

  always #5 clk = ~clk;

  always_comb begin
    key_in = '0;
    for (int r = 0; r < 5; r++) key_in[r] = |(pressed[r] & key_out);
  end

  key_scan_ctrl #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_FRAMES(DB)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_key_in     (key_in),
    .o_key_out    (key_out),
    .o_key_valid  (valid),
    .o_key_code   (code),
    .o_key_hold   (hold),
    .o_key_release(rel)
  );

  int total = 0;
  int bad = 0;

  // Reference model state: run lengths of identical frames rather than FSM states.
  int k;            // rising edges since reset release
  int samp [4];     // per-column sample of the current frame
  int last_code;    // code of the current run of identical nonzero frames (not held)
  int run;          // length of that run
  int rel_run;      // consecutive frames without the held key
  int held;         // accepted key, 0 if none
  int exp_code;
  logic exp_hold, exp_valid, exp_rel;

  int valid_cnt, rel_cnt, valid_k;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  function automatic int lowest_code(input int col);
    for (int r = 0; r < 5; r++) if (pressed[r][col]) return r * 4 + col + 1;
    return 0;
  endfunction

  function automatic int min_nz(input int a, input int b);
    if (a == 0) return b;
    if (b == 0) return a;
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < 4; c++) samp[c] = 0;
    last_code = 0;
    run = 0;
    rel_run = 0;
    held = 0;
    exp_code = 0;
    exp_hold = 1'b0;
    exp_valid = 1'b0;
    exp_rel = 1'b0;
  endtask

  // What the DUT does on the coming rising edge.
  task automatic model_edge();
    int col, fc;
    exp_valid = 1'b0;
    exp_rel = 1'b0;
    col = (k / SD) % 4;
    if (k % SD == SD - 1) begin
      samp[col] = lowest_code(col);
      if (col == 3) begin
        fc = 0;
        for (int c = 0; c < 4; c++) fc = min_nz(fc, samp[c]);
        if (held == 0) begin
          if (fc == 0) begin
            run = 0;
            last_code = 0;
          end else if (fc == last_code) begin
            run++;
          end else begin
            last_code = fc;
            run = 1;
          end
          if (run == DB) begin
            held = fc;
            exp_code = fc;
            exp_valid = 1'b1;
            exp_hold = 1'b1;
            rel_run = 0;
          end
        end else begin
          rel_run = (fc == held) ? 0 : rel_run + 1;
          if (rel_run == DB) begin
            held = 0;
            exp_hold = 1'b0;
            exp_rel = 1'b1;
            run = 0;
            last_code = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] eo;
    eo = 4'(1 << ((k / SD) % 4));
    check("key_out", 8'(key_out), 8'(eo));
    check("valid", 8'(valid), 8'(exp_valid));
    check("code", 8'(code), 8'(exp_code));
    check("hold", 8'(hold), 8'(exp_hold));
    check("release", 8'(rel), 8'(exp_rel));
    check("valid_release_excl", 8'(valid & rel), 8'd0);
  endtask

  // One clock: model the edge, let the DUT take it, compare, return at the falling edge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    k++;
    if (valid) begin
      valid_cnt++;
      valid_k = k;
    end
    if (rel) rel_cnt++;
    check_all();
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 5; r++) pressed[r] = 4'b0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_out"}, 8'(key_out), 8'h01);
    check({tag, "_valid"}, 8'(valid), 8'h00);
    check({tag, "_code"}, 8'(code), 8'h00);
    check({tag, "_hold"}, 8'(hold), 8'h00);
    check({tag, "_release"}, 8'(rel), 8'h00);
  endtask

  // Called at a falling edge; reset takes effect without waiting for a clock.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    int nk, r, c, len;
    clear_keys();
    model_reset();
    valid_cnt = 0;
    rel_cnt = 0;
    valid_k = -1;
    @(negedge clk);

    // Reset
    do_reset();

    // Column sequencing with no keys
    run_cycles(FR);
    check("seq_wrap_key_out", 8'(key_out), 8'h01);
    run_cycles(FR);
    check("seq_no_valid", 8'(valid_cnt), 8'd0);

    // Bounce: one frame pressed, one frame released, four times
    for (int i = 0; i < 4; i++) begin
      pressed[0][0] = 1'b1;
      run_cycles(FR);
      pressed[0][0] = 1'b0;
      run_cycles(FR);
    end
    check("bounce_no_valid", 8'(valid_cnt), 8'd0);
    check("bounce_code", 8'(code), 8'd0);

    // Press row1/col3 (code 8), frame-aligned
    valid_cnt = 0;
    valid_k = -1;
    pressed[1][3] = 1'b1;
    begin
      int k0;
      k0 = k;
      run_cycles(6 * FR);
      check("press_one_valid", 8'(valid_cnt), 8'd1);
      // Third frame end containing the key is at k0+3*FR-1; valid visible right after it.
      check("press_latency", 8'(valid_k - k0), 8'(3 * FR));
    end
    check("press_code", 8'(code), 8'd8);
    check("press_hold", 8'(hold), 8'd1);

    // One-frame dropout while held: no release
    rel_cnt = 0;
    pressed[1][3] = 1'b0;
    run_cycles(FR);
    pressed[1][3] = 1'b1;
    run_cycles(2 * FR);
    check("glitch_no_release", 8'(rel_cnt), 8'd0);
    check("glitch_hold", 8'(hold), 8'd1);

    // Release
    valid_cnt = 0;
    pressed[1][3] = 1'b0;
    run_cycles(4 * FR);
    check("release_one_pulse", 8'(rel_cnt), 8'd1);
    check("release_hold", 8'(hold), 8'd0);
    check("release_code_kept", 8'(code), 8'd8);
    check("release_no_valid", 8'(valid_cnt), 8'd0);

    // Multi-key: codes 2 and 9, lowest wins
    pressed[0][1] = 1'b1;
    pressed[2][0] = 1'b1;
    run_cycles(5 * FR + 3);
    check("multi_code", 8'(code), 8'd2);
    check("multi_hold", 8'(hold), 8'd1);

    // Reset while held: immediate return to reset values, no release pulse
    rel_cnt = 0;
    do_reset();
    clear_keys();
    run_cycles(2 * FR);
    check("rst_no_release", 8'(rel_cnt), 8'd0);

    // Randomized key activity checked cycle by cycle against the model
    for (int seg = 0; seg < 45; seg++) begin
      clear_keys();
      nk = $urandom_range(0, 2);
      for (int j = 0; j < nk; j++) begin
        r = $urandom_range(0, 4);
        c = $urandom_range(0, 3);
        pressed[r][c] = 1'b1;
      end
      len = (seg % 3 == 0) ? $urandom_range(60, 110) : $urandom_range(4, 40);
      run_cycles(len);
    end
    clear_keys();
    run_cycles(5 * FR);
    check("final_idle_hold", 8'(hold), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
